// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: sequential instruction fetcher with an in-order response FIFO and redirect flush.
// Optional IFQ_STARVE_CNT_EN adds a saturating starve_cnt output.
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
`ifdef IFQ_STARVE_CNT_EN
  output logic [31:0] starve_cnt,
`endif
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   tag_pc [DEPTH];
  logic [AW-1:0] q_rd, q_wr, t_rd, t_wr;
  logic [CW-1:0] count, outstanding, discard, occ, out_next;
  logic          req_fire, push, pop, drop;
  assign occ            = count + outstanding;
  assign imem_req_valid = !reset && !redirect_valid && (occ < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign drop           = imem_rsp_valid && (discard != '0);
  assign push           = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready && !redirect_valid;
  assign out_next       = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign instr_valid    = count != '0;
  assign instr_data     = instr_valid ? q_data[q_rd] : '0;
  assign instr_pc       = instr_valid ? q_pc[q_rd] : '0;
  // Every response retires one tag, even when it is discarded, so tags stay aligned.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc    <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (imem_rsp_valid) t_rd <= t_rd + 1'b1;
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        t_wr     <= t_wr + 1'b1;
      end
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        q_rd     <= '0;
        q_wr     <= '0;
        count    <= '0;
        discard  <= out_next;
      end else begin
        if (drop) discard <= discard - 1'b1;
        if (push) q_wr <= q_wr + 1'b1;
        if (pop) q_rd <= q_rd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk) begin
    if (req_fire) tag_pc[t_wr] <= fetch_pc;
    if (push) begin
      q_data[q_wr] <= imem_rsp_data;
      q_pc[q_wr]   <= tag_pc[t_rd];
    end
  end
`ifdef IFQ_STARVE_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_cnt <= '0;
    else if (instr_ready && !instr_valid && starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
`endif
  rsp_without_req: assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue: table-driven directed checks of fetch, backpressure, redirect and wrap behaviour.
module tb_ifetch_prefetch_queue;
  logic        clk = 0, reset = 0;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr_data, instr_pc;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
`ifdef IFQ_STARVE_CNT_EN
  logic [31:0] starve_cnt;
`endif
  int errors = 0, checks = 0;

  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
`ifdef IFQ_STARVE_CNT_EN
    .starve_cnt(starve_cnt),
`endif
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rr, rv; logic [31:0] rd; logic ir, xv; logic [31:0] xpc;
    logic erv; logic [31:0] era; logic eiv; logic [31:0] epc, edat;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic rr, rv, input logic [31:0] rd, input logic ir, xv, input logic [31:0] xpc,
                     input logic erv, input logic [31:0] era, input logic eiv, input logic [31:0] epc, edat);
    vec_t t;
    t.rr = rr; t.rv = rv; t.rd = rd; t.ir = ir; t.xv = xv; t.xpc = xpc;
    t.erv = erv; t.era = era; t.eiv = eiv; t.epc = epc; t.edat = edat;
    v.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rr, rv, input logic [31:0] rd, input logic ir, xv, input logic [31:0] xpc);
    imem_req_ready = rr; imem_rsp_valid = rv; imem_rsp_data = rd;
    instr_ready = ir; redirect_valid = xv; redirect_pc = xpc;
  endtask

  initial begin
    // steady fetch and backpressure
    add(1,0,0,1,0,0,                      1,32'h0,0,0,0);
    add(1,1,32'hDEAD0000,1,0,0,           1,32'h4,0,0,0);
    add(1,1,32'hDEAD0004,1,0,0,           1,32'h8,1,32'h0,32'hDEAD0000);
    add(1,1,32'hDEAD0008,1,0,0,           1,32'hC,1,32'h4,32'hDEAD0004);
    add(1,1,32'hDEAD000C,0,0,0,           1,32'h10,1,32'h8,32'hDEAD0008);
    add(1,1,32'hDEAD0010,0,0,0,           1,32'h14,1,32'h8,32'hDEAD0008);
    add(1,1,32'hDEAD0014,0,0,0,           0,32'h18,1,32'h8,32'hDEAD0008);
    add(1,0,0,0,0,0,                      0,32'h18,1,32'h8,32'hDEAD0008);
    add(1,0,0,1,0,0,                      0,32'h18,1,32'h8,32'hDEAD0008);
    add(1,0,0,1,0,0,                      1,32'h18,1,32'hC,32'hDEAD000C);
    add(1,1,32'hDEAD0018,1,0,0,           1,32'h1C,1,32'h10,32'hDEAD0010);
    add(0,1,32'hDEAD001C,0,0,0,           1,32'h20,1,32'h14,32'hDEAD0014);
    add(1,0,0,1,0,0,                      1,32'h20,1,32'h14,32'hDEAD0014);
    add(1,0,0,1,0,0,                      1,32'h24,1,32'h18,32'hDEAD0018);
    add(1,0,0,1,0,0,                      1,32'h28,1,32'h1C,32'hDEAD001C);
    // redirect with three in flight
    add(1,0,0,1,1,32'h103,                0,32'h2C,0,0,0);
    add(0,1,32'hDEAD0020,1,0,0,           1,32'h100,0,0,0);
    add(1,1,32'hDEAD0024,1,0,0,           1,32'h100,0,0,0);
    add(0,1,32'hDEAD0028,1,0,0,           1,32'h104,0,0,0);
    add(0,1,32'hDEAD0100,1,0,0,           1,32'h104,0,0,0);
    add(0,0,0,1,0,0,                      1,32'h104,1,32'h100,32'hDEAD0100);
    // redirect coinciding with a response, two in flight
    add(1,0,0,0,0,0,                      1,32'h104,0,0,0);
    add(1,0,0,0,0,0,                      1,32'h108,0,0,0);
    add(1,1,32'hDEAD0104,1,1,32'h200,     0,32'h10C,0,0,0);
    add(0,1,32'hDEAD0108,1,0,0,           1,32'h200,0,0,0);
    add(1,0,0,1,0,0,                      1,32'h200,0,0,0);
    add(0,1,32'hDEAD0200,1,0,0,           1,32'h204,0,0,0);
    add(0,0,0,1,0,0,                      1,32'h204,1,32'h200,32'hDEAD0200);
    // back-to-back redirects, address wrap, redirect with pop
    add(1,0,0,0,1,32'h300,                0,32'h204,0,0,0);
    add(1,0,0,0,1,32'hFFFFFFFB,           0,32'h300,0,0,0);
    add(1,0,0,0,0,0,                      1,32'hFFFFFFF8,0,0,0);
    add(1,1,32'h11111111,0,0,0,           1,32'hFFFFFFFC,0,0,0);
    add(1,1,32'h22222222,0,0,0,           1,32'h0,1,32'hFFFFFFF8,32'h11111111);
    add(1,1,32'h33333333,1,1,32'h400,     0,32'h4,1,32'hFFFFFFF8,32'h11111111);
    add(0,0,0,1,0,0,                      1,32'h400,0,0,0);

    reset = 1;
    #12;
    chk("reset_req_valid", 32'(imem_req_valid), 0);
    chk("reset_req_addr", imem_req_addr, 32'h0);
    chk("reset_instr_valid", 32'(instr_valid), 0);
    chk("reset_instr_data", instr_data, 0);
    chk("reset_instr_pc", instr_pc, 0);
    @(negedge clk) reset = 0;

    foreach (v[i]) begin
      if (i != 0) @(negedge clk);
      drive(v[i].rr, v[i].rv, v[i].rd, v[i].ir, v[i].xv, v[i].xpc);
      #2;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(v[i].erv));
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, v[i].era);
      chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(v[i].eiv));
      chk($sformatf("v%0d_instr_pc", i), instr_pc, v[i].epc);
      chk($sformatf("v%0d_instr_data", i), instr_data, v[i].edat);
    end

    // reset in the middle of an outstanding request
    @(negedge clk) drive(1,0,0,0,0,0);
    @(posedge clk) #2 reset = 1;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 0);
    chk("midrst_req_addr", imem_req_addr, 32'h0);
    chk("midrst_instr_valid", 32'(instr_valid), 0);
    @(negedge clk) reset = 0;
    #2;
    chk("postrst_req_valid", 32'(imem_req_valid), 1);
    chk("postrst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk) drive(0,1,32'hCAFE0000,0,0,0);
    @(negedge clk) drive(0,0,0,0,0,0);
    #2;
    chk("postrst_instr_valid", 32'(instr_valid), 1);
    chk("postrst_instr_pc", instr_pc, 32'h0);
    chk("postrst_instr_data", instr_data, 32'hCAFE0000);

`ifdef IFQ_STARVE_CNT_EN
    @(negedge clk) reset = 1;
    #2;
    chk("starve_reset", starve_cnt, 0);
    @(negedge clk) begin reset = 0; drive(0,0,0,1,0,0); end
    repeat (10) @(posedge clk);
    #2;
    chk("starve_cnt_10", starve_cnt, 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
